// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, big-endian lane offsets
// and the alignment rule used to reject requests before they reach memory.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    // Byte k sits at bits [31-8k -: 8]; the high half is offset 0, the low half offset 2
    localparam logic [1:0] OFS_BYTE0   = 2'd0;
    localparam logic [1:0] OFS_BYTE1   = 2'd1;
    localparam logic [1:0] OFS_BYTE2   = 2'd2;
    localparam logic [1:0] OFS_BYTE3   = 2'd3;
    localparam logic [1:0] OFS_HALF_HI = 2'd0;
    localparam logic [1:0] OFS_HALF_LO = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_WAIT,
        ST_RMW_WAIT
    } lsu_state_t;

    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != OFS_BYTE0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the pipeline request/response signals and the data-memory port seen by the LSU.
// The slave modport is the LSU's view; master is the pipeline/memory environment's view.
interface lsu_if #(parameter int ADDR_WIDTH = 32);

    logic                  req_valid;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  busy;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  misalign;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_write;
    logic                  mem_read;
    logic [31:0]           mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output busy, resp_valid, resp_rdata, misalign, mem_addr, mem_wdata, mem_write, mem_read
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  busy, resp_valid, resp_rdata, misalign, mem_addr, mem_wdata, mem_write, mem_read
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational big-endian lane steering: pulls a byte/half out of a memory word (with
// optional sign extension) and splices store data into a memory word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_extract,
    output logic [31:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[31:24];
        case (i_offset)
            OFS_BYTE1: w_byte = i_word[23:16];
            OFS_BYTE2: w_byte = i_word[15:8];
            OFS_BYTE3: w_byte = i_word[7:0];
            default:   w_byte = i_word[31:24];
        endcase
        w_half = (i_offset == OFS_HALF_LO) ? i_word[15:0] : i_word[31:16];

        o_extract = i_word;
        case (i_size)
            SZ_BYTE: o_extract = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_extract = {{16{i_signed & w_half[15]}}, w_half};
            default: o_extract = i_word;
        endcase

        o_merge = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_merge = i_word;
                case (i_offset)
                    OFS_BYTE1: o_merge[23:16] = i_wdata[7:0];
                    OFS_BYTE2: o_merge[15:8]  = i_wdata[7:0];
                    OFS_BYTE3: o_merge[7:0]   = i_wdata[7:0];
                    default:   o_merge[31:24] = i_wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                o_merge = i_word;
                if (i_offset == OFS_HALF_LO) o_merge[15:0] = i_wdata[15:0];
                else                         o_merge[31:16] = i_wdata[15:0];
            end
            default: o_merge = i_wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: word stores go straight out, loads and sub-word stores take one
// extra cycle through the synchronous-read memory, and misaligned requests are rejected.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
)
(
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);

    lsu_state_t            r_state;
    lsu_state_t            w_nextState;
    logic [1:0]            r_size;
    logic                  r_signed;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_respValid;
    logic [31:0]           r_respRdata;
    logic                  r_misalign;

    logic                  w_accept;
    logic                  w_misalignReq;
    logic                  w_start;
    logic                  w_memRead;
    logic                  w_memWrite;
    logic [ADDR_WIDTH-1:0] w_memAddr;
    logic [31:0]           w_memWdata;
    logic [31:0]           w_extract;
    logic [31:0]           w_merge;

    assign w_accept      = (r_state == ST_IDLE) && bus.req_valid && !rst;
    assign w_misalignReq = isMisaligned(bus.req_size, bus.req_addr[1:0]);
    assign w_start       = w_accept && !w_misalignReq;

    // mem_rdata carries the word read last cycle, so the latched request selects its lane
    lsu_lane_align u_laneAlign (
        .i_word    (bus.mem_rdata),
        .i_wdata   (r_wdata),
        .i_offset  (r_addr[1:0]),
        .i_size    (r_size),
        .i_signed  (r_signed),
        .o_extract (w_extract),
        .o_merge   (w_merge)
    );

    always_comb begin
        w_nextState = r_state;
        w_memRead   = 1'b0;
        w_memWrite  = 1'b0;
        w_memWdata  = bus.req_wdata;
        w_memAddr   = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    if (bus.req_write && bus.req_size == SZ_WORD) begin
                        w_memWrite = 1'b1;
                    end else begin
                        w_memRead   = 1'b1;
                        w_nextState = bus.req_write ? ST_RMW_WAIT : ST_LOAD_WAIT;
                    end
                end
            end
            ST_LOAD_WAIT: begin
                w_memAddr   = {r_addr[ADDR_WIDTH-1:2], 2'b00};
                w_nextState = ST_IDLE;
            end
            ST_RMW_WAIT: begin
                w_memAddr   = {r_addr[ADDR_WIDTH-1:2], 2'b00};
                w_memWdata  = w_merge;
                w_memWrite  = 1'b1;
                w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_respValid <= 1'b0;
            r_respRdata <= '0;
            r_misalign  <= 1'b0;
            r_size      <= SZ_BYTE;
            r_signed    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            r_state     <= w_nextState;
            r_respValid <= (r_state == ST_LOAD_WAIT);
            r_misalign  <= w_accept && w_misalignReq;
            if (r_state == ST_LOAD_WAIT) r_respRdata <= w_extract;
            if (w_start) begin
                r_size   <= bus.req_size;
                r_signed <= bus.req_signed;
                r_addr   <= bus.req_addr;
                r_wdata  <= bus.req_wdata;
            end
        end
    end

    // A reset landing mid-RMW must not let the merged write escape
    assign bus.mem_read   = w_memRead & ~rst;
    assign bus.mem_write  = w_memWrite & ~rst;
    assign bus.mem_addr   = w_memAddr;
    assign bus.mem_wdata  = w_memWdata;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.resp_valid = r_respValid;
    assign bus.resp_rdata = r_respRdata;
    assign bus.misalign   = r_misalign;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver predicts responses from a word-array memory
// model and queues them; a negedge monitor pops and compares whenever the DUT responds.
module tb_load_store_unit;
    import lsu_pkg::*;

    typedef struct packed {
        logic        isMis;
        logic [31:0] data;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        expQ[$];
    logic [31:0] refMem [0:15];
    logic [31:0] tbMem [0:15];
    logic [31:0] memRdata;
    logic        bdWrite = 1'b0;
    logic [3:0]  bdIdx = '0;
    logic [31:0] bdData = '0;
    logic [31:0] expHold = '0;
    logic        rstSeen = 1'b0;

    always #5 clk = ~clk;

    lsu_if #(.ADDR_WIDTH(32)) bus ();

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous-read data memory with a backdoor used only to preload it
    assign bus.mem_rdata = memRdata;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bdWrite) tbMem[bdIdx] <= bdData;
        if (bus.mem_write) tbMem[bus.mem_addr[5:2]] <= bus.mem_wdata;
        if (bus.mem_read) memRdata <= tbMem[bus.mem_addr[5:2]];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic modelMis(input logic [1:0] sz, input logic [31:0] addr);
        return (sz == 2'b11) || (sz == SZ_HALF && addr % 2 != 0) || (sz == SZ_WORD && addr % 4 != 0);
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [31:0] addr,
                                              input logic [1:0] sz, input logic sgn);
        int k = int'(addr % 4);
        logic [31:0] v;
        if (sz == SZ_BYTE) begin
            v = (word >> (8 * (3 - k))) & 32'hFF;
            if (sgn && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == SZ_HALF) begin
            v = (word >> (8 * (2 - k))) & 32'hFFFF;
            if (sgn && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] modelStore(input logic [31:0] word, input logic [31:0] addr,
                                               input logic [1:0] sz, input logic [31:0] wdata);
        int k = int'(addr % 4);
        int shift;
        logic [31:0] mask;
        if (sz == SZ_WORD) return wdata;
        shift = (sz == SZ_BYTE) ? 8 * (3 - k) : 8 * (2 - k);
        mask  = ((sz == SZ_BYTE) ? 32'hFF : 32'hFFFF) << shift;
        return (word & ~mask) | ((wdata << shift) & mask);
    endfunction

    // Present one request, wait for acceptance, check memory strobes and queue the response
    task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic useExp, input logic [31:0] expOverride);
        int waitCnt = 0;
        int c;
        logic mis;
        logic subStore;
        logic [31:0] expVal;
        logic [3:0] idx = addr[5:2];
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        while (bus.busy && waitCnt < 20) begin
            @(posedge clk);
            #1;
            waitCnt++;
        end
        if (bus.busy) begin
            checks++;
            errors++;
            $display("[TB] FAIL busy_timeout: got busy=1 expected 0");
            bus.req_valid = 1'b0;
            return;
        end
        c = cyc;
        #1;
        mis      = modelMis(sz, addr);
        subStore = wr && sz != SZ_WORD && !mis;
        expVal   = '0;
        if (mis) begin
            checkOutput("mis_mem_read", {31'b0, bus.mem_read}, 32'd0);
            checkOutput("mis_mem_write", {31'b0, bus.mem_write}, 32'd0);
            expQ.push_back('{isMis: 1'b1, data: 32'd0, cyc: 32'(c + 1)});
        end else begin
            checkOutput("c0_mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
            if (wr && sz == SZ_WORD) begin
                checkOutput("sw_mem_write", {31'b0, bus.mem_write}, 32'd1);
                checkOutput("sw_mem_read", {31'b0, bus.mem_read}, 32'd0);
                checkOutput("sw_mem_wdata", bus.mem_wdata, wdata);
                refMem[idx] = wdata;
            end else begin
                checkOutput("c0_mem_read", {31'b0, bus.mem_read}, 32'd1);
                checkOutput("c0_mem_write", {31'b0, bus.mem_write}, 32'd0);
                if (wr) begin
                    expVal      = useExp ? expOverride : modelStore(refMem[idx], addr, sz, wdata);
                    refMem[idx] = modelStore(refMem[idx], addr, sz, wdata);
                end else begin
                    expVal = useExp ? expOverride : modelLoad(refMem[idx], addr, sz, sgn);
                    expQ.push_back('{isMis: 1'b0, data: expVal, cyc: 32'(c + 2)});
                end
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        checkOutput("c1_busy", {31'b0, bus.busy}, (!mis && !(wr && sz == SZ_WORD)) ? 32'd1 : 32'd0);
        if (subStore) begin
            #1;
            checkOutput("rmw_mem_write", {31'b0, bus.mem_write}, 32'd1);
            checkOutput("rmw_mem_read", {31'b0, bus.mem_read}, 32'd0);
            checkOutput("rmw_mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
            checkOutput("rmw_mem_wdata", bus.mem_wdata, expVal);
        end
    endtask

    task automatic resetDuringRmw();
        int waitCnt = 0;
        bus.req_write  = 1'b1;
        bus.req_size   = SZ_BYTE;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h13;
        bus.req_wdata  = 32'h55;
        bus.req_valid  = 1'b1;
        while (bus.busy && waitCnt < 20) begin
            @(posedge clk);
            #1;
            waitCnt++;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        checkOutput("rst_rmw_busy", {31'b0, bus.busy}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_mem_write", {31'b0, bus.mem_write}, 32'd0);
        checkOutput("rst_mem_read", {31'b0, bus.mem_read}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rst_busy_after", {31'b0, bus.busy}, 32'd0);
        checkOutput("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    endtask

    // Monitor: every response is matched against the head of the scoreboard queue
    always @(negedge clk) begin
        exp_t e;
        if (rstSeen) expHold = '0;
        if (!rst) begin
            checkOutput("rd_wr_exclusive", {31'b0, bus.mem_read & bus.mem_write}, 32'd0);
            if (bus.resp_valid || bus.misalign) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_resp: got resp_valid=%0b misalign=%0b expected none",
                             bus.resp_valid, bus.misalign);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("resp_kind", {31'b0, bus.misalign}, {31'b0, e.isMis});
                    checkOutput("resp_cycle", 32'(cyc), e.cyc);
                    if (!e.isMis) begin
                        checkOutput("resp_rdata", bus.resp_rdata, e.data);
                        checkOutput("busy_at_resp", {31'b0, bus.busy}, 32'd0);
                        expHold = e.data;
                    end
                end
            end else begin
                checkOutput("resp_rdata_hold", bus.resp_rdata, expHold);
            end
        end
        rstSeen = rst;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] addr;
        int          r;
        int          drain;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = SZ_WORD;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            bdIdx     = 4'(i);
            bdData    = (i == 4) ? 32'h8899AABB : $urandom;
            refMem[i] = bdData;
            bdWrite   = 1'b1;
            @(posedge clk);
            #1;
        end
        bdWrite       = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h10;
        #1;
        checkOutput("rst_forces_read_low", {31'b0, bus.mem_read}, 32'd0);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        checkOutput("reset_busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("reset_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        checkOutput("reset_resp_rdata", bus.resp_rdata, 32'd0);
        checkOutput("reset_misalign", {31'b0, bus.misalign}, 32'd0);

        applyStimulus(1'b0, SZ_BYTE, 1'b1, 32'h12, 32'h0, 1'b1, 32'hFFFFFFAA);
        applyStimulus(1'b0, SZ_BYTE, 1'b0, 32'h12, 32'h0, 1'b1, 32'h000000AA);
        applyStimulus(1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, 1'b1, 32'hFFFF8899);
        applyStimulus(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 1'b1, 32'h0000AABB);
        applyStimulus(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h55, 1'b1, 32'h8855AABB);
        applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 32'h8855AABB);
        applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h01234567, 1'b0, 32'h0);
        applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 32'h01234567);
        applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h8899AABB, 1'b0, 32'h0);
        applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h11, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, SZ_HALF, 1'b0, 32'h13, 32'hBEEF, 1'b0, 32'h0);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 32'h8899AABB);
        resetDuringRmw();
        applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 32'h8899AABB);

        for (int n = 0; n < 200; n++) begin
            r    = int'($urandom_range(0, 15));
            sz   = (r == 15) ? 2'b11 : 2'(r % 3);
            addr = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == SZ_WORD) addr = addr & ~32'h3;
                else if (sz == SZ_HALF) addr = addr & ~32'h1;
            end
            applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom, 1'b0, 32'h0);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        drain = 0;
        while (expQ.size() != 0 && drain < 20) begin
            @(posedge clk);
            #1;
            drain++;
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
        for (int i = 0; i < 16; i++) begin
            checkOutput("mem_word", tbMem[i], refMem[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit between the MIPS pipeline MEM stage and the byte-addressed, big-endian, synchronous-read data memory. It turns pipeline load/store requests (byte, halfword, word; signed/unsigned loads) into aligned 32-bit memory accesses. It performs read-modify-write for sub-word stores, extracts and extends load data, flags misaligned accesses, and stalls the pipeline while a multi-cycle access is in flight.

## Interface
- ADDR_WIDTH, 32, byte address width. Data width is fixed at 32.

Clock and reset: one clock; reset is synchronous and active-high.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  sign-extend load result (ignored for stores and words)
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data; byte in [7:0], half in [15:0]
- busy  out  1  pipeline stall; high whenever state ≠ IDLE
- resp_valid  out  1  one-cycle pulse, load data valid
- resp_rdata  out  32  extracted/extended load data
- misalign  out  1  one-cycle pulse, request rejected
- mem_addr  out  ADDR_WIDTH  word-aligned address (req_addr & ~3)
- mem_wdata  out  32  full word to write
- mem_write  out  1  memory write strobe
- mem_read  out  1  memory read strobe
- mem_rdata  in  32  memory read data, valid the cycle after mem_read

## Operation
- Acceptance: a request is accepted when state = IDLE, req_valid = 1 and rst = 0. The pipeline holds req_* stable while busy = 1. Accepted fields are latched for later states.
- Byte lanes are big-endian. Offset k = addr[1:0]: byte k is bits [31-8k -: 8]. Half at offset 0 is [31:16]; half at offset 2 is [15:0].
- Misalign: half with addr[0] = 1, word with addr[1:0] ≠ 0, or size = 11.
  - No mem_read or mem_write is issued.
  - misalign pulses the next cycle; state stays IDLE.
- FSM states: IDLE, LOAD_WAIT, RMW_WAIT.
- IDLE, word store:
  - mem_write = 1 combinationally, mem_wdata = req_wdata.
  - Stays IDLE; busy stays 0; no resp_valid.
- IDLE, load:
  - mem_read = 1 combinationally.
  - Transition to LOAD_WAIT.
- IDLE, sub-word store:
  - mem_read = 1.
  - Transition to RMW_WAIT.
- LOAD_WAIT:
  - Extract the lane from mem_rdata; zero- or sign-extend per latched req_signed.
  - Register the result into resp_rdata, set resp_valid, return to IDLE.
- RMW_WAIT:
  - mem_wdata = mem_rdata with the target lane replaced by latched wdata; mem_write = 1.
  - Return to IDLE.
- mem_read and mem_write are never both 1 in the same cycle.
- resp_rdata holds its value until the next load completes.

## Timing
- Reset values: busy 0, resp_valid 0, resp_rdata 0, misalign 0, state IDLE. While rst = 1, mem_read and mem_write are forced to 0.
- Load: accept at cycle 0, LOAD_WAIT at cycle 1 (busy = 1), resp_valid at cycle 2. A new request may be accepted in cycle 2.
- Word store: 1 cycle, zero stall.
- Sub-word store: accept at cycle 0 (read), merged write at cycle 1 (busy = 1), IDLE at cycle 2.
- Back-to-back:
  - A load immediately after a word store returns the new data, because the memory write commits at the cycle-0 edge.
  - A load immediately after a sub-word store is accepted at cycle 2.
- Reset mid-operation: state returns to IDLE with no memory write issued; a pending RMW is abandoned and no resp_valid is produced.

## Structure
- Package lsu_pkg:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - state enum;
  - lane offset constants.
- Sub-module lsu_lane_align (combinational):
  - extract (word, offset, size, signed) → 32-bit result;
  - merge (word, wdata, offset, size) → 32-bit result.
  - Used by both the LOAD_WAIT and RMW_WAIT paths.
- The top level holds the FSM, the request latch, and the output registers.

## Test plan
In every scenario, the memory word at 0x10 initially holds 0x8899AABB.
- Byte loads:
  - lb at 0x12 → resp_valid at cycle 2, resp_rdata 0xFFFFFFAA.
  - lbu at 0x12 → 0x000000AA.
  - busy is high only in cycle 1.
- Halfword loads:
  - lh at 0x10 → 0xFFFF8899.
  - lhu at 0x12 → 0x0000AABB.
- Byte store: sb at 0x11 with wdata 0x00000055.
  - mem_read in cycle 0, mem_addr 0x10.
  - mem_write in cycle 1 with mem_wdata 0x8855AABB.
  - A following lw at 0x10 returns 0x8855AABB.
- Word store: sw at 0x10 with 0x01234567.
  - mem_write in cycle 0, busy never asserts.
  - A lw at 0x10 in cycle 1 returns 0x01234567 at cycle 3.
- Misaligned accesses: lw at 0x11, then sh at 0x13, then size = 11.
  - Each produces a misalign pulse the next cycle.
  - mem_read, mem_write and resp_valid stay 0; the memory word is unchanged.
- Reset during RMW: assert rst during RMW_WAIT of sb at 0x13.
  - mem_write never asserts.
  - busy = 0 after reset.
  - The memory word remains 0x8899AABB.
